// File: rtl/beep_tone_gen_if.sv
// Request/speaker signal bundle between the beep decision logic and the tone generator.
// The slave side is the tone generator; the master side drives requests and mute.
interface beep_tone_gen_if;
    logic       beep512Hz;
    logic       beep1kHz;
    logic       mute;
    logic       spk;
    logic       busy;
    logic [1:0] tone;

    modport master (
        output beep512Hz,
        output beep1kHz,
        output mute,
        input  spk,
        input  busy,
        input  tone
    );

    modport slave (
        input  beep512Hz,
        input  beep1kHz,
        input  mute,
        output spk,
        output busy,
        output tone
    );
endinterface

// File: rtl/beep_tone_gen.sv
// Converts level beep requests into fixed-length square-wave bursts on the speaker pin.
// A rising request edge starts or restarts a burst; 1 kHz pre-empts 512 Hz, mute aborts.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | no burst, speaker low
//   ST_T512 | 512 Hz burst in progress
//   ST_T1K  | 1 kHz burst in progress (512 Hz rises ignored)
module beep_tone_gen #(
    parameter int HALF_512     = 97656,
    parameter int HALF_1K      = 50000,
    parameter int BURST_CYCLES = 20000000
) (
    input  logic           clk,
    input  logic           rst,
    beep_tone_gen_if.slave bus
);

    localparam int HALF_MAX = (HALF_512 > HALF_1K) ? HALF_512 : HALF_1K;
    localparam int HW       = $clog2(HALF_MAX);
    localparam int BW       = $clog2(BURST_CYCLES);

    localparam logic [HW-1:0] HALF_512_LAST = HW'(HALF_512 - 1);
    localparam logic [HW-1:0] HALF_1K_LAST  = HW'(HALF_1K - 1);
    localparam logic [BW-1:0] BURST_LAST    = BW'(BURST_CYCLES - 1);

    // Encoding doubles as the tone output code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_T512 = 2'b01,
        ST_T1K  = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_half_cnt;
    logic [HW-1:0]   w_half_nxt;
    logic [BW-1:0]   r_burst_cnt;
    logic [BW-1:0]   w_burst_nxt;
    logic            r_spk;
    logic            w_spk_nxt;
    logic            r_r512_q;
    logic            r_r1k_q;
    logic            w_rise_512;
    logic            w_rise_1k;
    logic            w_start;
    logic            w_end;
    logic            w_burst_done;
    logic [HW-1:0]   w_half_last;

    assign w_rise_512   = bus.beep512Hz & ~r_r512_q;
    assign w_rise_1k    = bus.beep1kHz  & ~r_r1k_q;
    assign w_burst_done = (r_burst_cnt == BURST_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r512_q <= 1'b0;
            r_r1k_q  <= 1'b0;
        end else begin
            r_r512_q <= bus.beep512Hz;
            r_r1k_q  <= bus.beep1kHz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_half_cnt  <= '0;
            r_burst_cnt <= '0;
            r_spk       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_half_cnt  <= w_half_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_spk       <= w_spk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half_cnt;
        w_burst_nxt = r_burst_cnt;
        w_spk_nxt   = r_spk;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_half_last = (r_state == ST_T1K) ? HALF_1K_LAST : HALF_512_LAST;

        if (bus.mute) begin
            w_state_nxt = ST_IDLE;
            w_end       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise_1k) begin
                        w_state_nxt = ST_T1K;
                        w_start     = 1'b1;
                    end else if (w_rise_512) begin
                        w_state_nxt = ST_T512;
                        w_start     = 1'b1;
                    end
                end
                ST_T512: begin
                    if (w_rise_1k) begin
                        w_state_nxt = ST_T1K;
                        w_start     = 1'b1;
                    end else if (w_rise_512) begin
                        w_state_nxt = ST_T512;
                        w_start     = 1'b1;
                    end else if (w_burst_done) begin
                        w_state_nxt = ST_IDLE;
                        w_end       = 1'b1;
                    end
                end
                ST_T1K: begin
                    if (w_rise_1k) begin
                        w_state_nxt = ST_T1K;
                        w_start     = 1'b1;
                    end else if (w_burst_done) begin
                        w_state_nxt = ST_IDLE;
                        w_end       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end
            endcase
        end

        if (w_start) begin
            w_half_nxt  = '0;
            w_burst_nxt = '0;
            w_spk_nxt   = 1'b1;
        end else if (w_end) begin
            w_half_nxt  = '0;
            w_burst_nxt = '0;
            w_spk_nxt   = 1'b0;
        end else if (r_state != ST_IDLE) begin
            w_burst_nxt = r_burst_cnt + BW'(1);
            if (r_half_cnt == w_half_last) begin
                w_half_nxt = '0;
                w_spk_nxt  = ~r_spk;
            end else begin
                w_half_nxt = r_half_cnt + HW'(1);
            end
        end
    end

    assign bus.spk  = r_spk;
    assign bus.busy = (r_state != ST_IDLE);
    assign bus.tone = 2'(r_state);

endmodule

// File: tb/tb_beep_tone_gen.sv
// Scoreboarded bench for beep_tone_gen: a burst-timeline reference model predicts every
// post-edge output; a separate monitor pops and compares after each rising clock edge.
module tb_beep_tone_gen;

    localparam int HALF_512     = 4;
    localparam int HALF_1K      = 2;
    localparam int BURST_CYCLES = 20;

    typedef struct {
        logic       spk;
        logic       busy;
        logic [1:0] tone;
    } exp_t;

    logic clk;
    logic rst;
    beep_tone_gen_if bif ();

    beep_tone_gen #(
        .HALF_512    (HALF_512),
        .HALF_1K     (HALF_1K),
        .BURST_CYCLES(BURST_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: which tone is sounding and how many cycles since it started.
    int   m_prev512 = 0;
    int   m_prev1k  = 0;
    int   m_active  = 0;
    int   m_elapsed = 0;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   half;
        half   = (m_active == 2) ? HALF_1K : HALF_512;
        e.busy = (m_active != 0);
        e.tone = 2'(m_active);
        e.spk  = (m_active != 0) && (((m_elapsed / half) % 2) == 0);
        return e;
    endfunction

    // Advance the model by one clock edge given the inputs it will sample.
    task automatic model_step(input bit r, input bit m, input bit b512, input bit b1k);
        bit rise512, rise1k;
        if (r) begin
            m_prev512 = 0;
            m_prev1k  = 0;
            m_active  = 0;
            m_elapsed = 0;
        end else begin
            rise512   = b512 && (m_prev512 == 0);
            rise1k    = b1k  && (m_prev1k  == 0);
            m_prev512 = b512;
            m_prev1k  = b1k;
            if (m) begin
                m_active = 0;
            end else if (rise1k) begin
                m_active  = 2;
                m_elapsed = 0;
            end else if (rise512 && m_active != 2) begin
                m_active  = 1;
                m_elapsed = 0;
            end else if (m_active != 0) begin
                m_elapsed++;
                if (m_elapsed >= BURST_CYCLES) m_active = 0;
            end
        end
        exp_q.push_back(model_out());
    endtask

    // One cycle of stimulus, applied on the falling edge ahead of the next rising edge.
    task automatic step(input bit r, input bit m, input bit b512, input bit b1k);
        @(negedge clk);
        rst           = r;
        bif.mute      = m;
        bif.beep512Hz = b512;
        bif.beep1kHz  = b1k;
        if (r) begin
            #1;
            chk("rst_spk",  {1'b0, bif.spk},  2'd0);
            chk("rst_busy", {1'b0, bif.busy}, 2'd0);
            chk("rst_tone", bif.tone,         2'd0);
        end
        model_step(r, m, b512, b1k);
    endtask

    task automatic run(input int n, input bit m, input bit b512, input bit b1k);
        for (int i = 0; i < n; i++) step(1'b0, m, b512, b1k);
    endtask

    // Monitor: compares each post-edge output against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("spk",  {1'b0, bif.spk},  {1'b0, e.spk});
                chk("busy", {1'b0, bif.busy}, {1'b0, e.busy});
                chk("tone", bif.tone,         e.tone);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, m, b512, b1k;
        rst           = 1'b1;
        bif.mute      = 1'b0;
        bif.beep512Hz = 1'b0;
        bif.beep1kHz  = 1'b0;
        #2;
        chk("init_spk",  {1'b0, bif.spk},  2'd0);
        chk("init_busy", {1'b0, bif.busy}, 2'd0);
        chk("init_tone", bif.tone,         2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0, 1'b0);

        // 512 Hz held long: one burst only
        run(40, 1'b0, 1'b1, 1'b0);
        run(4, 1'b0, 1'b0, 1'b0);
        // 1 kHz burst
        run(25, 1'b0, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0, 1'b0);
        // 1 kHz pre-empts a 512 Hz burst at burst cycle 7
        run(7, 1'b0, 1'b1, 1'b0);
        run(30, 1'b0, 1'b1, 1'b1);
        run(3, 1'b0, 1'b0, 1'b0);
        // 512 Hz rise during a 1 kHz burst is ignored
        run(5, 1'b0, 1'b0, 1'b1);
        run(25, 1'b0, 1'b1, 1'b1);
        run(3, 1'b0, 1'b0, 1'b0);
        // simultaneous rises, then 512 must drop and rise again
        run(25, 1'b0, 1'b1, 1'b1);
        run(2, 1'b0, 1'b0, 1'b1);
        run(22, 1'b0, 1'b1, 1'b1);
        run(3, 1'b0, 1'b0, 1'b0);
        // retrigger a 512 Hz burst
        run(6, 1'b0, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        run(25, 1'b0, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0, 1'b0);
        // async reset at burst cycle 10 with 1 kHz held
        run(10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        run(25, 1'b0, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0, 1'b0);
        // mute mid-burst, then a rise while muted
        run(6, 1'b0, 1'b1, 1'b0);
        run(3, 1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0, 1'b0);

        // random traffic
        r = 0; m = 0; b512 = 0; b1k = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) b512 = ~b512;
            if ($urandom_range(0, 19) == 0) b1k  = ~b1k;
            if (m) m = ($urandom_range(0, 5) != 0);
            else   m = ($urandom_range(0, 79) == 0);
            r = ($urandom_range(0, 299) == 0);
            step(r, m, b512, b1k);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 2'(exp_q.size() > 0 ? 1 : 0), 2'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
